fc_sequencer: RTL and testbench
===============================

# fc_sequencer

Sequencing controller for the 16-lane fully-connected datapath (`Full_Connect_0`). For one layer it walks every output neuron and, for each neuron, every 16-word input chunk. It drives the read addresses of the feature and weight memories, tracks the datapath's fixed latency with a valid pipeline, and accumulates the per-chunk partial results. Each finished neuron's saturated 16-bit result is written to the result memory. It sits between the layer-level control FSM and the FC datapath and its SRAMs.

## Interface
- `LANES`, 16, datapath lanes per chunk (fixed by datapath)
- `CHUNKS`, 8, input chunks per neuron (input length = CHUNKS*LANES)
- `MAX_OUT`, 512, maximum neurons per layer
- `MUL_LAT`, 3, datapath latency from memory-data-valid to `i_fc_result` valid
- `ACC_W`, 24, signed accumulator width
- `clk`  in  1  clock, all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `i_start`  in  1  one-cycle pulse; begin layer (ignored while busy)
- `i_out_num`  in  $clog2(MAX_OUT+1)  neurons this layer, sampled on accepted start
- `o_busy`  out  1  high from accepted start until done pulse inclusive
- `o_done`  out  1  one-cycle pulse after last result written
- `o_feat_addr`  out  $clog2(CHUNKS)  feature memory chunk address
- `o_wgt_addr`  out  $clog2(MAX_OUT*CHUNKS)  weight memory address = neuron*CHUNKS+chunk
- `o_mem_en`  out  1  read enable to both memories (1-cycle read latency)
- `i_fc_result`  in  16  signed partial sum from datapath
- `o_wr_en`  out  1  result memory write strobe
- `o_wr_addr`  out  $clog2(MAX_OUT)  neuron index
- `o_wr_data`  out  16  saturated neuron result

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: outputs low/zero. `i_start` with `i_out_num`>0 → latch count, clear neuron/chunk counters → ISSUE. `i_start` with `i_out_num`==0 → DONE directly; no reads, no writes.
- ISSUE: each cycle assert `o_mem_en` with current (neuron, chunk). Push a tag into the valid pipeline: valid, first=(chunk==0), last=(chunk==CHUNKS-1), neuron. Chunk increments and wraps to 0, then neuron increments. After issuing (count-1, CHUNKS-1) → DRAIN. Issue is back-to-back with no bubbles.
- Valid pipeline depth = 1+MUL_LAT, aligned so that a tag's exit coincides with its `i_fc_result`.
- Accumulate on tag exit, with r = sign-extended `i_fc_result` to ACC_W:
  - first: acc ← r
  - else: acc ← acc + r (wraps at ACC_W; ACC_W sized so wrap cannot occur for CHUNKS≤256)
- On a last tag, write sum = (first ? r : acc+r), saturated to [-32768, 32767], to `o_wr_addr`=tag neuron. This covers CHUNKS==1.
- DRAIN: wait until the pipeline is empty (last write issued) → DONE.
- DONE: `o_done`=1 for one cycle → IDLE. `o_busy` drops the cycle after.
- `i_start` while not IDLE: ignored, with no effect on the latched count.
- Reset at any time: immediately IDLE, pipeline cleared, no spurious write after release.

## Timing
- Reset values: `o_busy`, `o_done`, `o_mem_en`, `o_wr_en`=0; all addresses and `o_wr_data`=0; accumulator 0.
- Start accepted at cycle 0 → first `o_mem_en` at cycle 1.
- Read issued at cycle t → memory data at t+1 → `i_fc_result` at t+1+MUL_LAT.
- Write for a neuron is registered: `o_wr_en` at t_last+2+MUL_LAT, where t_last is that neuron's last issue cycle.
- Total busy = 1 + N*CHUNKS + MUL_LAT + 2 + 1 cycles (N = neurons).
- Throughput: one chunk per clock; one neuron result every CHUNKS clocks.
- All outputs registered.

## Structure
- Shared package `fc_pkg`: LANES, CHUNKS, MAX_OUT, MUL_LAT, ACC_W defaults; state enum; tag struct {valid, first, last, neuron}; `sat16` function.
- One natural sub-module: `fc_tag_pipe`, a parameterised shift register of tags (depth 1+MUL_LAT, async clear). The accumulator and FSM stay in the top.

## Test plan
- N=2, CHUNKS=8, datapath model returns 100 per chunk → writes addr0=800, addr1=800; `o_done` exactly 1+16+MUL_LAT+3 cycles after start.
- Mixed signs: chunk results alternate +30000/−29999, CHUNKS=8 → write 4; separately all +20000 → write saturates to 32767, all −20000 → −32768.
- `i_out_num`=0 → `o_done` pulse 2 cycles after start; no `o_mem_en`, no `o_wr_en`.
- `i_start` re-pulsed mid-layer with a different count → ignored; write count equals the original N.
- Address sweep N=3, CHUNKS=8: `o_wgt_addr` runs 0..23 contiguously and `o_feat_addr` cycles 0..7 three times.
- Reset asserted during DRAIN → outputs zero asynchronously; after release no write occurs and a fresh start runs a full correct layer.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the FC layer sequencer: default geometry, FSM states,
// the per-read tag that travels alongside the datapath, and output saturation.
package fc_pkg;

   localparam int unsigned LANES   = 16;
   localparam int unsigned CHUNKS  = 8;
   localparam int unsigned MAX_OUT = 512;
   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned ACC_W   = 24;
   localparam int unsigned NEUR_W  = $clog2(MAX_OUT);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } fc_state_e;

   typedef struct packed {
      logic              valid;
      logic              first;
      logic              last;
      logic [NEUR_W-1:0] neuron;
   } fc_tag_t;

   function automatic logic [15:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767) begin
         return 16'h7fff;
      end else if (v < -32'sd32768) begin
         return 16'h8000;
      end else begin
         return v[15:0];
      end
   endfunction

endpackage

// File: rtl/fc_tag_pipe.sv
// Shift register of read tags; the output stage lines up with the datapath result
// belonging to that read. busy reports any valid tag still in flight.
module fc_tag_pipe #(
   parameter int unsigned DEPTH = 1 + fc_pkg::MUL_LAT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  fc_pkg::fc_tag_t tag_in,
   output fc_pkg::fc_tag_t tag_out,
   output logic            busy
);
   import fc_pkg::*;

   fc_tag_t stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         busy = busy | stage_q[i].valid;
      end
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/fc_sequencer.sv
// Layer sequencer for the 16-lane FC datapath: issues (neuron, chunk) reads back to back,
// follows them through the datapath with tags and accumulates each neuron's partial sums.
module fc_sequencer #(
   parameter int unsigned CHUNKS  = fc_pkg::CHUNKS,
   parameter int unsigned MAX_OUT = fc_pkg::MAX_OUT,
   parameter int unsigned MUL_LAT = fc_pkg::MUL_LAT,
   parameter int unsigned ACC_W   = fc_pkg::ACC_W,
   localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1),
   localparam int unsigned CHK_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
   localparam int unsigned WGT_W  = $clog2(MAX_OUT * CHUNKS),
   localparam int unsigned IDX_W  = $clog2(MAX_OUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_out_num,
   output logic             o_busy,
   output logic             o_done,
   output logic [CHK_W-1:0] o_feat_addr,
   output logic [WGT_W-1:0] o_wgt_addr,
   output logic             o_mem_en,
   input  logic [15:0]      i_fc_result,
   output logic             o_wr_en,
   output logic [IDX_W-1:0] o_wr_addr,
   output logic [15:0]      o_wr_data
);
   import fc_pkg::*;

   fc_state_e state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] neuron_q, neuron_d;
   logic [CHK_W-1:0] chunk_q, chunk_d;
   logic [WGT_W-1:0] wgt_q, wgt_d;
   logic             mem_en_q, mem_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wr_en_q, wr_en_d;
   logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]      wr_data_q, wr_data_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] fc_ext, acc_sum;

   fc_tag_t tag_in, tag_out;
   logic    pipe_busy;
   logic    chunk_last, issue_last;

   fc_tag_pipe #(
      .DEPTH (1 + MUL_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag_in),
      .tag_out (tag_out),
      .busy    (pipe_busy)
   );

   assign chunk_last = (chunk_q == CHK_W'(CHUNKS - 1));
   assign issue_last = chunk_last && (CNT_W'(neuron_q) == count_q - CNT_W'(1));

   always_comb begin
      tag_in = '0;
      if (state_q == StIssue) begin
         tag_in.valid  = 1'b1;
         tag_in.first  = (chunk_q == '0);
         tag_in.last   = chunk_last;
         tag_in.neuron = neuron_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      neuron_d = neuron_q;
      chunk_d  = chunk_q;
      wgt_d    = wgt_q;
      unique case (state_q)
         StIdle: begin
            // busy_q still covers the done cycle, so a start there is dropped
            if (i_start && !busy_q) begin
               if (i_out_num != '0) begin
                  count_d  = i_out_num;
                  neuron_d = '0;
                  chunk_d  = '0;
                  wgt_d    = '0;
                  state_d  = StIssue;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StIssue: begin
            if (issue_last) begin
               neuron_d = '0;
               chunk_d  = '0;
               wgt_d    = '0;
               state_d  = StDrain;
            end else begin
               wgt_d = wgt_q + WGT_W'(1);
               if (chunk_last) begin
                  chunk_d  = '0;
                  neuron_d = neuron_q + IDX_W'(1);
               end else begin
                  chunk_d = chunk_q + CHK_W'(1);
               end
            end
         end
         StDrain: begin
            if (!pipe_busy) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      mem_en_d = (state_d == StIssue);
      busy_d   = (state_d != StIdle) || (state_q == StDone);
      done_d   = (state_q == StDone);
   end

   always_comb begin
      fc_ext    = {{(ACC_W - 16){i_fc_result[15]}}, i_fc_result};
      acc_sum   = tag_out.first ? fc_ext : acc_q + fc_ext;
      acc_d     = acc_q;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      if (tag_out.valid) begin
         acc_d = acc_sum;
         if (tag_out.last) begin
            wr_en_d   = 1'b1;
            wr_addr_d = tag_out.neuron;
            wr_data_d = sat16({{(32 - ACC_W){acc_sum[ACC_W-1]}}, acc_sum});
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         count_q   <= '0;
         neuron_q  <= '0;
         chunk_q   <= '0;
         wgt_q     <= '0;
         mem_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         neuron_q  <= neuron_d;
         chunk_q   <= chunk_d;
         wgt_q     <= wgt_d;
         mem_en_q  <= mem_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         acc_q     <= acc_d;
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_feat_addr = chunk_q;
   assign o_wgt_addr  = wgt_q;
   assign o_mem_en    = mem_en_q;
   assign o_wr_en     = wr_en_q;
   assign o_wr_addr   = wr_addr_q;
   assign o_wr_data   = wr_data_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer: memory/datapath model plus a reference of per-neuron sums,
// expected issue order and cycle timing derived from the layer size.
module tb_fc_sequencer;

   localparam int C = 8;
   localparam int M = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [9:0]  i_out_num = '0;
   logic        o_busy, o_done, o_mem_en, o_wr_en;
   logic [2:0]  o_feat_addr;
   logic [11:0] o_wgt_addr;
   logic [15:0] i_fc_result = '0;
   logic [8:0]  o_wr_addr;
   logic [15:0] o_wr_data;

   int n_checks = 0;
   int n_err = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int tbl [4096];
   int dp [M+1];
   int mon_wr_addr[$], mon_wr_data[$], mon_wr_cyc[$];
   int mon_iss_wgt[$], mon_iss_feat[$], mon_iss_cyc[$];
   int mon_done[$];

   typedef struct {
      int n;
      int a;
      int b;
      int exp;
   } vec_t;
   vec_t vecs [6];

   fc_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_out_num   (i_out_num),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_feat_addr (o_feat_addr),
      .o_wgt_addr  (o_wgt_addr),
      .o_mem_en    (o_mem_en),
      .i_fc_result (i_fc_result),
      .o_wr_en     (o_wr_en),
      .o_wr_addr   (o_wr_addr),
      .o_wr_data   (o_wr_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor plus memory/datapath model: read at cycle t shows up as a result in t+1+M
   always @(negedge clk) begin
      if (o_mem_en) begin
         mon_iss_wgt.push_back(int'(o_wgt_addr));
         mon_iss_feat.push_back(int'(o_feat_addr));
         mon_iss_cyc.push_back(cyc);
      end
      if (o_wr_en) begin
         mon_wr_addr.push_back(int'(o_wr_addr));
         mon_wr_data.push_back(int'($signed(o_wr_data)));
         mon_wr_cyc.push_back(cyc);
      end
      if (o_done) mon_done.push_back(cyc);
      if (o_busy) busy_cnt++;
      i_fc_result = 16'(dp[M]);
      for (int i = M; i > 0; i--) dp[i] = dp[i-1];
      dp[0] = o_mem_en ? tbl[o_wgt_addr] : 0;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic int model_neuron(input int n);
      int s = 0;
      for (int c = 0; c < C; c++) s += tbl[n*C + c];
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic clear_mon();
      mon_wr_addr.delete();
      mon_wr_data.delete();
      mon_wr_cyc.delete();
      mon_iss_wgt.delete();
      mon_iss_feat.delete();
      mon_iss_cyc.delete();
      mon_done.delete();
      busy_cnt = 0;
   endtask

   // Called right after a falling edge with the DUT idle
   task automatic run_layer(input int n, input int roff, input int rn);
      int  s;
      int  lat;
      bit  seen;
      clear_mon();
      s = cyc;
      i_start = 1'b1;
      i_out_num = 10'(n);
      seen = 1'b0;
      for (int k = 1; k <= n*C + 40; k++) begin
         @(negedge clk);
         i_start = (k == roff);
         if (k == roff) i_out_num = 10'(rn);
         if (o_done) begin
            seen = 1'b1;
            break;
         end
      end
      i_start = 1'b0;
      if (!seen) check("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      lat = (n == 0) ? 2 : n*C + M + 4;
      check("wr_count", mon_wr_addr.size(), n);
      for (int i = 0; i < mon_wr_addr.size() && i < n; i++) begin
         check($sformatf("wr_addr[%0d]", i), mon_wr_addr[i], i);
         check($sformatf("wr_data[%0d]", i), mon_wr_data[i], model_neuron(i));
         check($sformatf("wr_cycle[%0d]", i), mon_wr_cyc[i] - s, (i+1)*C + 2 + M);
      end
      check("issue_count", mon_iss_wgt.size(), n*C);
      for (int k = 0; k < mon_iss_wgt.size() && k < n*C; k++) begin
         check($sformatf("wgt_addr[%0d]", k), mon_iss_wgt[k], k);
         check($sformatf("feat_addr[%0d]", k), mon_iss_feat[k], k % C);
         check($sformatf("issue_cycle[%0d]", k), mon_iss_cyc[k] - s, 1 + k);
      end
      check("done_count", mon_done.size(), 1);
      if (mon_done.size() > 0) check("done_latency", mon_done[0] - s, lat);
      check("busy_cycles", busy_cnt, lat);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_err);
      $fatal(1);
   end

   initial begin
      vecs[0] = '{n: 2, a: 100,    b: 100,    exp: 800};
      vecs[1] = '{n: 1, a: 30000,  b: -29999, exp: 4};
      vecs[2] = '{n: 1, a: 20000,  b: 20000,  exp: 32767};
      vecs[3] = '{n: 1, a: -20000, b: -20000, exp: -32768};
      vecs[4] = '{n: 3, a: 7,      b: -3,     exp: 16};
      vecs[5] = '{n: 2, a: 32767,  b: -32768, exp: -4};
      for (int i = 0; i <= M; i++) dp[i] = 0;
      for (int i = 0; i < 4096; i++) tbl[i] = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_mem_en", o_mem_en, 0);
      check("rst_wr_en", o_wr_en, 0);
      check("rst_addrs", {o_feat_addr, o_wgt_addr, o_wr_addr}, 0);
      check("rst_wr_data", o_wr_data, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven layers: chunk results alternate a/b
      foreach (vecs[r]) begin
         for (int k = 0; k < vecs[r].n * C; k++) tbl[k] = (k % 2 == 0) ? vecs[r].a : vecs[r].b;
         run_layer(vecs[r].n, -1, 0);
         for (int i = 0; i < mon_wr_data.size() && i < vecs[r].n; i++)
            check($sformatf("vec%0d_data[%0d]", r, i), mon_wr_data[i], vecs[r].exp);
      end

      // Empty layer
      run_layer(0, -1, 0);

      // Start re-pulsed mid-layer with another count
      for (int k = 0; k < 3*C; k++) tbl[k] = k * 11 - 50;
      run_layer(3, 5, 7);

      // Randomized layers against the reference sums
      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(1, 5));
         for (int k = 0; k < n*C; k++)
            tbl[k] = (r % 2 == 1) ? int'($urandom_range(0, 65535)) - 32768
                                  : int'($urandom_range(0, 2000)) - 1000;
         run_layer(n, -1, 0);
      end

      // Reset during drain: outputs clear at once, no late write
      for (int k = 0; k < C; k++) tbl[k] = 1000;
      clear_mon();
      i_start = 1'b1;
      i_out_num = 10'd1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (C + 1) @(negedge clk);
      check("drain_busy", o_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", o_busy, 0);
      check("arst_mem_en", o_mem_en, 0);
      check("arst_wr_en", o_wr_en, 0);
      check("arst_done", o_done, 0);
      check("arst_addrs", {o_feat_addr, o_wgt_addr, o_wr_addr}, 0);
      check("arst_wr_data", o_wr_data, 0);
      clear_mon();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("post_rst_writes", mon_wr_addr.size(), 0);
      check("post_rst_done", mon_done.size(), 0);
      check("post_rst_issues", mon_iss_wgt.size(), 0);
      for (int k = 0; k < 2*C; k++) tbl[k] = 300 - k * 37;
      run_layer(2, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
